// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared flash state encoding, colour constants and range helper for the arena overlay
package draw_pkg;

    localparam int RGB_W = 12;

    localparam logic [RGB_W-1:0] RGB_BLACK     = 12'h000;
    localparam logic [RGB_W-1:0] LINE_RGB_DEF  = 12'hfff;
    localparam logic [RGB_W-1:0] FLASH_RGB_DEF = 12'hf00;

    typedef enum logic [1:0] {
        FLASH_IDLE = 2'd0,
        FLASH_L    = 2'd1,
        FLASH_R    = 2'd2
    } flash_state_e;

    // Inclusive range test on a 12-bit screen coordinate
    function automatic logic in_range(
        input logic [11:0] v,
        input logic [11:0] lo,
        input logic [11:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/arena_flash_fsm.sv
// rtl/arena_flash_fsm.sv - goal flash sequencer: vsync frame tick, flash FSM, frame counter and blink phase
module arena_flash_fsm
    import draw_pkg::*;
#(
    parameter int FLASH_FRAMES = 120,
    parameter int BLINK_FRAMES = 15
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic vsync_in,
    input  logic goal_left_in,
    input  logic goal_right_in,
    output logic flash_active,
    output logic flash_l_on,
    output logic flash_r_on
);

    localparam int FCW = $clog2(FLASH_FRAMES + 1);
    localparam int BCW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FLASH_FRAMES - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

    flash_state_e   state;
    logic [FCW-1:0] frame_cnt;
    logic [BCW-1:0] blink_cnt;
    logic           blink;
    logic           vsync_d;
    logic           tick;

    assign tick = vsync_in & ~vsync_d;

    // Registered copy of vsync for rising-edge frame tick detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync_in;
        end
    end

    // Flash FSM: goal pulses (re)start a flash and swallow a coincident tick; left beats right
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FLASH_IDLE;
            frame_cnt <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (goal_left_in) begin
            state     <= FLASH_L;
            frame_cnt <= '0;
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (goal_right_in) begin
            state     <= FLASH_R;
            frame_cnt <= '0;
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else begin
            case (state)
                FLASH_IDLE: begin
                    frame_cnt <= '0;
                    blink_cnt <= '0;
                    blink     <= 1'b0;
                end
                FLASH_L, FLASH_R: begin
                    if (tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            state     <= FLASH_IDLE;
                            frame_cnt <= '0;
                            blink_cnt <= '0;
                            blink     <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= '0;
                                blink     <= ~blink;
                            end else begin
                                blink_cnt <= blink_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state     <= FLASH_IDLE;
                    frame_cnt <= '0;
                    blink_cnt <= '0;
                    blink     <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decode straight from state registers so they carry no combinational input path
    assign flash_active = (state == FLASH_L) || (state == FLASH_R);
    assign flash_l_on   = (state == FLASH_L) && blink;
    assign flash_r_on   = (state == FLASH_R) && blink;

endmodule

// File: rtl/draw_arena.sv
// rtl/draw_arena.sv - three-stage pixel pipeline overlaying field lines, centre ring and flashing goals
module draw_arena
    import draw_pkg::*;
#(
    parameter int               H_RES        = 1024,
    parameter int               V_RES        = 768,
    parameter int               MARGIN       = 39,
    parameter int               LINE_W       = 8,
    parameter int               GOAL_H       = 201,
    parameter int               CIRCLE_R     = 120,
    parameter int               FLASH_FRAMES = 120,
    parameter int               BLINK_FRAMES = 15,
    parameter logic [RGB_W-1:0] LINE_RGB     = LINE_RGB_DEF,
    parameter logic [RGB_W-1:0] FLASH_RGB    = FLASH_RGB_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [11:0]      hcount_in,
    input  logic             hsync_in,
    input  logic             hblnk_in,
    input  logic [11:0]      vcount_in,
    input  logic             vsync_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             goal_left_in,
    input  logic             goal_right_in,
    output logic [11:0]      hcount_out,
    output logic [11:0]      vcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic             flash_active_out
);

    // Outline extents (outer edges) and bar inner edges
    localparam logic [11:0] OL_X0  = 12'(MARGIN);
    localparam logic [11:0] OL_X0I = 12'(MARGIN + LINE_W - 1);
    localparam logic [11:0] OL_X1  = 12'(H_RES - 1 - MARGIN);
    localparam logic [11:0] OL_X1I = 12'(H_RES - MARGIN - LINE_W);
    localparam logic [11:0] OL_Y0  = 12'(MARGIN);
    localparam logic [11:0] OL_Y0I = 12'(MARGIN + LINE_W - 1);
    localparam logic [11:0] OL_Y1  = 12'(V_RES - 1 - MARGIN);
    localparam logic [11:0] OL_Y1I = 12'(V_RES - MARGIN - LINE_W);

    // Centre line columns
    localparam logic [11:0] CL_X0 = 12'(H_RES / 2 - LINE_W / 2);
    localparam logic [11:0] CL_X1 = 12'(H_RES / 2 - LINE_W / 2 + LINE_W - 1);

    // Goal boxes span from the screen edge up to and including the outline bar
    localparam logic [11:0] G_Y0   = 12'(V_RES / 2 - GOAL_H / 2);
    localparam logic [11:0] G_Y0I  = 12'(V_RES / 2 - GOAL_H / 2 + LINE_W - 1);
    localparam logic [11:0] G_Y1   = 12'(V_RES / 2 - GOAL_H / 2 + GOAL_H - 1);
    localparam logic [11:0] G_Y1I  = 12'(V_RES / 2 - GOAL_H / 2 + GOAL_H - LINE_W);
    localparam logic [11:0] GL_X1  = 12'(MARGIN + LINE_W - 1);
    localparam logic [11:0] GL_XB  = 12'(LINE_W - 1);
    localparam logic [11:0] GR_X0  = 12'(H_RES - MARGIN - LINE_W);
    localparam logic [11:0] GR_XB  = 12'(H_RES - LINE_W);
    localparam logic [11:0] X_LAST = 12'(H_RES - 1);

    // Ring bounds on squared distance, fixed at elaboration
    localparam logic [25:0] RING_IN2  = 26'(CIRCLE_R * CIRCLE_R);
    localparam logic [25:0] RING_OUT2 = 26'((CIRCLE_R + LINE_W) * (CIRCLE_R + LINE_W));

    localparam logic signed [12:0] HALF_H = 13'(H_RES / 2);
    localparam logic signed [12:0] HALF_V = 13'(V_RES / 2);

    logic flash_l_on;
    logic flash_r_on;
    logic flash_active;

    arena_flash_fsm #(
        .FLASH_FRAMES(FLASH_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_flash (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .vsync_in     (vsync_in),
        .goal_left_in (goal_left_in),
        .goal_right_in(goal_right_in),
        .flash_active (flash_active),
        .flash_l_on   (flash_l_on),
        .flash_r_on   (flash_r_on)
    );

    assign flash_active_out = flash_active;

    // Stage 1 registers
    logic [11:0]      s1_h, s1_v;
    logic             s1_hs, s1_hb, s1_vs, s1_vb;
    logic [RGB_W-1:0] s1_rgb;
    logic signed [12:0] s1_dx, s1_dy;
    logic             s1_fl, s1_fr;

    // Stage 2 registers
    logic [11:0]      s2_h, s2_v;
    logic             s2_hs, s2_hb, s2_vs, s2_vb;
    logic [RGB_W-1:0] s2_rgb;
    logic [25:0]      s2_d2;
    logic             s2_line, s2_goal_l, s2_goal_r;
    logic             s2_fl, s2_fr;

    // Stage 1: capture the pixel, its centre offset and the flash phase current at entry
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_h   <= '0;
            s1_v   <= '0;
            s1_hs  <= 1'b0;
            s1_hb  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_vb  <= 1'b0;
            s1_rgb <= '0;
            s1_dx  <= '0;
            s1_dy  <= '0;
            s1_fl  <= 1'b0;
            s1_fr  <= 1'b0;
        end else begin
            s1_h   <= hcount_in;
            s1_v   <= vcount_in;
            s1_hs  <= hsync_in;
            s1_hb  <= hblnk_in;
            s1_vs  <= vsync_in;
            s1_vb  <= vblnk_in;
            s1_rgb <= rgb_in;
            s1_dx  <= $signed({1'b0, hcount_in}) - HALF_H;
            s1_dy  <= $signed({1'b0, vcount_in}) - HALF_V;
            s1_fl  <= flash_l_on;
            s1_fr  <= flash_r_on;
        end
    end

    logic signed [25:0] dx_w, dy_w;
    logic [25:0]        d2_c;
    logic               line_c, goal_l_c, goal_r_c;
    logic               out_l, out_r, out_t, out_b, ctr;
    logic               gl_top, gl_bot, gl_back, gr_back;

    assign dx_w = 26'(s1_dx);
    assign dy_w = 26'(s1_dy);
    assign d2_c = $unsigned(dx_w * dx_w) + $unsigned(dy_w * dy_w);

    // Rectangle hit tests for outline, centre line and both goal boxes
    always_comb begin
        out_l    = in_range(s1_h, OL_X0, OL_X0I) && in_range(s1_v, OL_Y0, OL_Y1);
        out_r    = in_range(s1_h, OL_X1I, OL_X1) && in_range(s1_v, OL_Y0, OL_Y1);
        out_t    = in_range(s1_v, OL_Y0, OL_Y0I) && in_range(s1_h, OL_X0, OL_X1);
        out_b    = in_range(s1_v, OL_Y1I, OL_Y1) && in_range(s1_h, OL_X0, OL_X1);
        ctr      = in_range(s1_h, CL_X0, CL_X1) && in_range(s1_v, OL_Y0, OL_Y1);
        line_c   = out_l || out_r || out_t || out_b || ctr;
        gl_top   = in_range(s1_v, G_Y0, G_Y0I);
        gl_bot   = in_range(s1_v, G_Y1I, G_Y1);
        gl_back  = in_range(s1_h, 12'd0, GL_XB) && in_range(s1_v, G_Y0, G_Y1);
        gr_back  = in_range(s1_h, GR_XB, X_LAST) && in_range(s1_v, G_Y0, G_Y1);
        goal_l_c = in_range(s1_h, 12'd0, GL_X1) && (gl_top || gl_bot || gl_back);
        goal_r_c = in_range(s1_h, GR_X0, X_LAST) && (gl_top || gl_bot || gr_back);
    end

    // Stage 2: squared radius and rectangle flags, timing carried along
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s2_h      <= '0;
            s2_v      <= '0;
            s2_hs     <= 1'b0;
            s2_hb     <= 1'b0;
            s2_vs     <= 1'b0;
            s2_vb     <= 1'b0;
            s2_rgb    <= '0;
            s2_d2     <= '0;
            s2_line   <= 1'b0;
            s2_goal_l <= 1'b0;
            s2_goal_r <= 1'b0;
            s2_fl     <= 1'b0;
            s2_fr     <= 1'b0;
        end else begin
            s2_h      <= s1_h;
            s2_v      <= s1_v;
            s2_hs     <= s1_hs;
            s2_hb     <= s1_hb;
            s2_vs     <= s1_vs;
            s2_vb     <= s1_vb;
            s2_rgb    <= s1_rgb;
            s2_d2     <= d2_c;
            s2_line   <= line_c;
            s2_goal_l <= goal_l_c;
            s2_goal_r <= goal_r_c;
            s2_fl     <= s1_fl;
            s2_fr     <= s1_fr;
        end
    end

    logic ring_c;
    logic flash_hit_c;

    assign ring_c      = (s2_d2 >= RING_IN2) && (s2_d2 <= RING_OUT2);
    assign flash_hit_c = (s2_goal_l && s2_fl) || (s2_goal_r && s2_fr);

    // Stage 3: colour priority blank > flashing goal > line/ring > background
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= s2_h;
            vcount_out <= s2_v;
            hsync_out  <= s2_hs;
            hblnk_out  <= s2_hb;
            vsync_out  <= s2_vs;
            vblnk_out  <= s2_vb;
            if (s2_hb || s2_vb) begin
                rgb_out <= RGB_BLACK;
            end else if (flash_hit_c) begin
                rgb_out <= FLASH_RGB;
            end else if (s2_line || ring_c) begin
                rgb_out <= LINE_RGB;
            end else begin
                rgb_out <= s2_rgb;
            end
        end
    end

endmodule

// File: tb/tb_draw_arena.sv
// tb/tb_draw_arena.sv - vector table plus scoreboard bench for draw_arena geometry, flash and reset
module tb_draw_arena;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b1, vsync_in = 1'b0, vblnk_in = 1'b1;
    logic        goal_left_in = 1'b0, goal_right_in = 1'b0;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out, flash_active_out;

    always #5 clk_in = ~clk_in;

    draw_arena dut (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .hcount_in       (hcount_in),
        .hsync_in        (hsync_in),
        .hblnk_in        (hblnk_in),
        .vcount_in       (vcount_in),
        .vsync_in        (vsync_in),
        .vblnk_in        (vblnk_in),
        .rgb_in          (rgb_in),
        .goal_left_in    (goal_left_in),
        .goal_right_in   (goal_right_in),
        .hcount_out      (hcount_out),
        .vcount_out      (vcount_out),
        .hsync_out       (hsync_out),
        .hblnk_out       (hblnk_out),
        .vsync_out       (vsync_out),
        .vblnk_out       (vblnk_out),
        .rgb_out         (rgb_out),
        .flash_active_out(flash_active_out)
    );

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        hs, hb, vs, vb;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        int h;
        int v;
        bit hb;
        bit vb;
        int sel;   // 0 black, 1 line colour, 2 background
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic drv_valid = 1'b0;
    logic [2:0] vpipe;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Bench-side latency tracker: an output is due three edges after a valid pixel was driven
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) vpipe <= 3'b000;
        else        vpipe <= {vpipe[1:0], drv_valid};
    end

    // Scoreboard: compare each due output against the oldest expectation
    always @(negedge clk_in) begin
        if (rst_n && vpipe[2]) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rgb(%0d,%0d)", e.h, e.v), 64'(rgb_out), 64'(e.rgb));
                check($sformatf("timing(%0d,%0d)", e.h, e.v),
                      64'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}),
                      64'({e.h, e.v, e.hs, e.hb, e.vs, e.vb}));
            end
        end
    end

    function automatic logic [11:0] bg();
        return 12'h100 + 12'($urandom_range(0, 255));
    endfunction

    function automatic bit on_at(input int f);
        return (f < 120) && (((f / 15) % 2) == 0);
    endfunction

    task automatic set_px(input int h, input int v, input bit hb, input bit vb,
                          input logic [11:0] rgb, input logic [11:0] exp_rgb);
        exp_t e;
        hcount_in = 12'(h);
        vcount_in = 12'(v);
        hsync_in  = hcount_in[0];
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        drv_valid = 1'b1;
        e.h = hcount_in; e.v = vcount_in; e.hs = hsync_in; e.hb = hb;
        e.vs = vsync_in; e.vb = vb; e.rgb = exp_rgb;
        sb.push_back(e);
    endtask

    task automatic drive_px(input int h, input int v, input logic [11:0] rgb, input logic [11:0] exp_rgb);
        @(posedge clk_in); #1;
        set_px(h, v, 1'b0, 1'b0, rgb, exp_rgb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
            drv_valid = 1'b0;
            hblnk_in  = 1'b1;
            vblnk_in  = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk_in); #1;
        drv_valid = 1'b0;
        vsync_in  = 1'b1;
        @(posedge clk_in); #1;
        vsync_in  = 1'b0;
    endtask

    task automatic pulse(input bit l, input bit r, input bit vs);
        @(posedge clk_in); #1;
        drv_valid     = 1'b0;
        goal_left_in  = l;
        goal_right_in = r;
        if (vs) vsync_in = 1'b1;
        @(posedge clk_in); #1;
        goal_left_in  = 1'b0;
        goal_right_in = 1'b0;
        vsync_in      = 1'b0;
    endtask

    task automatic do_reset();
        idle(4);
        @(posedge clk_in); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;
    endtask

    task automatic goal_pair(input string tag, input int f, input bit l_on, input bit r_on);
        logic [11:0] a, b;
        a = bg();
        b = bg();
        drive_px(20, 286, a, l_on ? 12'hf00 : a);
        drive_px(1000, 286, b, r_on ? 12'hf00 : b);
        @(negedge clk_in);
        check($sformatf("%s_active_f%0d", tag, f), 64'(flash_active_out), 64'(l_on | r_on | (f < 120)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] r;

        // Reset behaviour with live inputs, then first pixel latency
        hcount_in = 12'd5; vcount_in = 12'd7; rgb_in = 12'habc;
        hblnk_in = 1'b0; vblnk_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            check("reset_rgb", 64'(rgb_out), 64'd0);
            check("reset_hcount", 64'(hcount_out), 64'd0);
            check("reset_active", 64'(flash_active_out), 64'd0);
        end
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        set_px(0, 0, 1'b0, 1'b0, 12'h5a5, 12'h5a5);
        idle(2);
        @(negedge clk_in);
        check("latency_early_rgb", 64'(rgb_out), 64'd0);
        idle(4);

        // Geometry vectors with no flash running
        tbl.push_back('{39, 100, 0, 0, 1});
        tbl.push_back('{46, 100, 0, 0, 1});
        tbl.push_back('{47, 100, 0, 0, 2});
        tbl.push_back('{38, 100, 0, 0, 2});
        tbl.push_back('{60, 100, 0, 0, 2});
        tbl.push_back('{512, 200, 0, 0, 1});
        tbl.push_back('{508, 200, 0, 0, 1});
        tbl.push_back('{515, 200, 0, 0, 1});
        tbl.push_back('{507, 200, 0, 0, 2});
        tbl.push_back('{516, 200, 0, 0, 2});
        tbl.push_back('{984, 400, 0, 0, 1});
        tbl.push_back('{985, 400, 0, 0, 2});
        tbl.push_back('{100, 39, 0, 0, 1});
        tbl.push_back('{100, 728, 0, 0, 1});
        tbl.push_back('{100, 729, 0, 0, 2});
        tbl.push_back('{632, 384, 0, 0, 1});
        tbl.push_back('{631, 384, 0, 0, 2});
        tbl.push_back('{640, 384, 0, 0, 1});
        tbl.push_back('{641, 384, 0, 0, 2});
        tbl.push_back('{512, 384, 0, 0, 1});
        tbl.push_back('{20, 286, 0, 0, 2});
        tbl.push_back('{4, 384, 0, 0, 2});
        tbl.push_back('{42, 286, 0, 0, 1});
        tbl.push_back('{39, 100, 1, 0, 0});
        tbl.push_back('{600, 300, 0, 1, 0});
        tbl.push_back('{632, 384, 1, 1, 0});
        foreach (tbl[i]) begin
            r = bg();
            @(posedge clk_in); #1;
            set_px(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, r,
                   (tbl[i].sel == 0) ? 12'h000 : (tbl[i].sel == 1) ? 12'hfff : r);
        end
        idle(5);

        // Left goal flash over 130 frames
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        r = bg();
        drive_px(42, 286, r, 12'hf00);
        for (int f = 0; f < 130; f++) begin
            goal_pair("flash", f, on_at(f), 1'b0);
            tick();
        end
        idle(4);
        check("flash_end_active", 64'(flash_active_out), 64'd0);

        // Simultaneous pulses, then right pulse with a coincident frame tick at frame 50
        do_reset();
        pulse(1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 50; f++) begin
            goal_pair("contend_l", f, on_at(f), 1'b0);
            tick();
        end
        pulse(1'b0, 1'b1, 1'b1);
        for (int g = 0; g < 125; g++) begin
            goal_pair("contend_r", g, 1'b0, on_at(g));
            tick();
        end
        idle(4);

        // Reset in the middle of a flash
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 30; f++) tick();
        r = bg();
        drive_px(20, 286, r, 12'hf00);
        idle(4);
        @(negedge clk_in);
        check("abort_active_before", 64'(flash_active_out), 64'd1);
        @(posedge clk_in); #3;
        rst_n = 1'b0;
        #1;
        check("abort_active_async", 64'(flash_active_out), 64'd0);
        check("abort_rgb_async", 64'(rgb_out), 64'd0);
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        r = bg();
        drive_px(20, 286, r, r);
        drive_px(42, 286, r, 12'hfff);
        idle(5);
        check("abort_active_after", 64'(flash_active_out), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/draw_arena.md
DRAW_ARENA -- requirements
Module: draw_arena

Interface
REQ-001 Parameters SHALL be:
- H_RES, 1024, active width in pixels
- V_RES, 768, active height in pixels
- MARGIN, 39, offset of the field outline from the screen edge
- LINE_W, 8, line thickness in pixels
- GOAL_H, 201, goal mouth height in pixels
- CIRCLE_R, 120, centre-circle radius to the inner edge
- FLASH_FRAMES, 120, duration of the goal flash in frames
- BLINK_FRAMES, 15, frames per half-period of the flash blink
- LINE_RGB, 12'hfff, line colour
- FLASH_RGB, 12'hf00, goal colour while the blink phase is on
REQ-002 Clock and reset SHALL be asynchronous and active-low: clk_in input 1 (pixel clock); rst_n input 1 (asynchronous reset, active low).
REQ-003 Timing inputs SHALL be: hcount_in input 12; hsync_in input 1; hblnk_in input 1; vcount_in input 12; vsync_in input 1; vblnk_in input 1; rgb_in input 12 (background pixel).
REQ-004 Event inputs SHALL be: goal_left_in input 1 (one-cycle score pulse, left goal); goal_right_in input 1 (one-cycle score pulse, right goal).
REQ-005 Outputs SHALL be: hcount_out, vcount_out output 12; hsync_out, hblnk_out, vsync_out, vblnk_out output 1; rgb_out output 12; flash_active_out output 1 (high while any flash is running).

Function
REQ-006 All timing outputs SHALL equal the corresponding inputs delayed by exactly 3 clk_in cycles, and rgb_out SHALL belong to the same pixel.
REQ-007 Stage 1 SHALL register the inputs together with signed 13-bit dx = hcount - H_RES/2 and dy = vcount - V_RES/2.
REQ-008 Stage 2 SHALL register the unsigned 26-bit d2 = dx*dx + dy*dy, with no truncation, plus the rectangle-hit flags.
REQ-009 Stage 3 SHALL register rgb_out, choosing the first match in this priority order:
- blanking gives 0
- goal region while the blink phase is on gives FLASH_RGB
- any line or ring gives LINE_RGB
- otherwise rgb_in
REQ-010 The outline SHALL be four LINE_W-thick bars whose outer edges are at MARGIN and H_RES-1-MARGIN horizontally and at MARGIN and V_RES-1-MARGIN vertically.
REQ-011 The centre line SHALL be LINE_W wide and centred on H_RES/2.
REQ-012 The ring SHALL be drawn where CIRCLE_R^2 <= d2 <= (CIRCLE_R+LINE_W)^2, with constants computed at elaboration.
REQ-013 Each goal SHALL be a three-sided LINE_W box running from the screen edge to the outline, vertically centred, GOAL_H tall; goal region means the box outline.
REQ-014 The flash FSM SHALL have three states:
- IDLE, which goes to FLASH_L on goal_left_in and to FLASH_R on goal_right_in
- FLASH_L, which returns to IDLE when the frame counter reaches FLASH_FRAMES
- FLASH_R, which returns to IDLE when the frame counter reaches FLASH_FRAMES
REQ-015 A frame tick SHALL be the rising edge of vsync_in, detected with a registered copy of vsync_in.
REQ-016 The frame counter SHALL clear on every state entry.
REQ-017 The blink phase SHALL start on, toggle every BLINK_FRAMES ticks, and be forced off in IDLE.
REQ-018 If goal_left_in and goal_right_in are high in the same cycle, goal_left_in SHALL win.
REQ-019 A pulse arriving during a flash SHALL restart the flash for the newly pulsed side, with counter cleared and blink phase on.
REQ-020 A goal pulse and a frame tick in the same cycle SHALL give the restart precedence, and the tick SHALL be ignored.
REQ-021 flash_active_out SHALL be high in FLASH_L and FLASH_R.
REQ-022 Flash colouring SHALL take effect on pixels entering stage 1 from the cycle after the state update; no mid-pixel glitch is allowed.

Reset
REQ-023 While rst_n is low, all pipeline registers and outputs SHALL be 0, the FSM SHALL be IDLE, and the counters and blink phase SHALL be 0.
REQ-024 Reset asserted during a flash SHALL abort it immediately.
REQ-025 After rst_n deasserts, the first valid output SHALL appear 3 cycles later.

Structure
REQ-026 A shared package draw_pkg SHALL hold the flash state encoding, the RGB width constant, and the colour constants.
REQ-027 One sub-module, arena_flash_fsm, SHALL contain the vsync edge detection, the FSM, the frame counter and the blink logic.
REQ-028 Geometry and pipeline logic SHALL stay in draw_arena.

Verification
REQ-029 Reset test: hold rst_n low with active inputs, then release; rgb_out SHALL be 0 during reset, and pixel (0,0) SHALL appear 3 cycles after release.
REQ-030 Geometry test with defaults: in a full frame, pixel (39,100) SHALL be 12'hfff; (60,100) SHALL equal rgb_in; (512,200) SHALL be 12'hfff; blanked pixels SHALL be 0.
REQ-031 Ring test with defaults: (632,384), d2=14400, SHALL be 12'hfff; (631,384) SHALL equal rgb_in; (640,384), d2=16384, SHALL be 12'hfff; (641,384) SHALL equal rgb_in.
REQ-032 Flash test: pulse goal_left_in once, then run 130 frames; the left goal box SHALL be 12'hf00 for frames 0-14, rgb_in-coloured for frames 15-29, and so on, and flash_active_out SHALL fall after frame 120.
REQ-033 Contention test: pulse both goals in the same cycle, giving FLASH_L; then pulse goal_right_in at frame 50, giving FLASH_R with the counter at 0, and the right box SHALL flash for a further 120 frames.
REQ-034 Abort test: pull rst_n low at frame 30 of a flash; flash_active_out SHALL fall asynchronously and the goal box SHALL show LINE_RGB after recovery.
